// File: rtl/disp_pkg.sv
// Shared constants and the display word layout for the 7-segment scan controller.
package disp_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int SCAN_W = 3;
  localparam logic [NUM_DIGITS-1:0] LES_RESET = 8'hFF;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] hex;
    logic [NUM_DIGITS-1:0]   point;
    logic [NUM_DIGITS-1:0]   les;
    logic [NUM_DIGITS-1:0]   blink;
  } disp_word_t;

  localparam disp_word_t DISP_RESET = '{hex: '0, point: '0, les: LES_RESET, blink: '0};

  // Blinking digits are forced blank during the high half of the blink period.
  function automatic logic [NUM_DIGITS-1:0] effective_les(input disp_word_t w, input logic phase);
    return w.les | (w.blink & {NUM_DIGITS{phase}});
  endfunction
endpackage

// File: rtl/disp_scan_ctrl_if.sv
// CPU write port and multiplexer-facing outputs of the scan controller.
interface disp_scan_ctrl_if;
  import disp_pkg::*;

  logic                    wr_en;
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   point_in;
  logic [NUM_DIGITS-1:0]   les_in;
  logic [NUM_DIGITS-1:0]   blink_in;
  logic                    wr_busy;
  logic [4*NUM_DIGITS-1:0] hexs;
  logic [NUM_DIGITS-1:0]   point;
  logic [NUM_DIGITS-1:0]   les;
  logic [SCAN_W-1:0]       scan;
  logic                    scan_tick;
  logic                    frame_start;

  // Handshake: wr_en is a one-cycle strobe that is always accepted (no ready);
  // wr_busy high means a captured write is held until the next frame boundary.
  modport master (
    output wr_en, data_in, point_in, les_in, blink_in,
    input  wr_busy, hexs, point, les, scan, scan_tick, frame_start
  );
  modport slave (
    input  wr_en, data_in, point_in, les_in, blink_in,
    output wr_busy, hexs, point, les, scan, scan_tick, frame_start
  );
endinterface

// File: rtl/clk_prescaler.sv
// Free-running divider; tick is high for one clock every 2^DIV_W clocks.
module clk_prescaler #(
  parameter int DIV_W = 17
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  logic [DIV_W-1:0] div;

  always_ff @(posedge clk) begin
    if (rst) div <= '0;
    else     div <= div + DIV_W'(1);
  end

  assign tick = &div;
endmodule

// File: rtl/disp_scan_ctrl.sv
// Digit scan counter plus tear-free shadow registers committed only at frame boundaries.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DIV_W   = 17,
  parameter int BLINK_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  disp_scan_ctrl_if.slave  bus
);
  logic               tick;
  logic               frame_start;
  logic [SCAN_W-1:0]  scan_q;
  logic [BLINK_W-1:0] frame_cnt;
  logic               busy_q;
  disp_word_t         pend_q;
  disp_word_t         shadow_q;
  disp_word_t         wr_word;

  clk_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign frame_start = tick && (scan_q == SCAN_W'(NUM_DIGITS - 1));
  assign wr_word     = '{hex: bus.data_in, point: bus.point_in, les: bus.les_in, blink: bus.blink_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q    <= '0;
      frame_cnt <= '0;
      busy_q    <= 1'b0;
      pend_q    <= '0;
      shadow_q  <= DISP_RESET;
    end else begin
      if (tick)        scan_q    <= scan_q + SCAN_W'(1);
      if (frame_start) frame_cnt <= frame_cnt + BLINK_W'(1);
      // A write landing on the boundary edge bypasses the pending stage.
      if (bus.wr_en && frame_start) begin
        shadow_q <= wr_word;
        pend_q   <= '0;
        busy_q   <= 1'b0;
      end else if (bus.wr_en) begin
        pend_q <= wr_word;
        busy_q <= 1'b1;
      end else if (frame_start && busy_q) begin
        shadow_q <= pend_q;
        pend_q   <= '0;
        busy_q   <= 1'b0;
      end
    end
  end

  assign bus.wr_busy     = busy_q;
  assign bus.hexs        = shadow_q.hex;
  assign bus.point       = shadow_q.point;
  assign bus.les         = effective_les(shadow_q, frame_cnt[BLINK_W-1]);
  assign bus.scan        = scan_q;
  assign bus.scan_tick   = tick;
  assign bus.frame_start = frame_start;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized scoreboard bench for disp_scan_ctrl with a cycle-count reference model.
module tb_disp_scan_ctrl;
  import disp_pkg::*;

  localparam int DIV_W   = 2;
  localparam int BLINK_W = 1;
  localparam int TICK    = 1 << DIV_W;
  localparam int FRAME   = NUM_DIGITS * TICK;
  localparam int W       = 4*NUM_DIGITS + 2*NUM_DIGITS + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  disp_scan_ctrl_if bus();

  disp_scan_ctrl #(.DIV_W(DIV_W), .BLINK_W(BLINK_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    bus.wr_en    = 1'b0;
    bus.data_in  = '0;
    bus.point_in = '0;
    bus.les_in   = '0;
    bus.blink_in = '0;
  end

  // ---------------- reference model ----------------
  int         total = 0;
  int         bad   = 0;
  logic [W-1:0] exp_q[$];
  disp_word_t m_sh, m_pw;
  bit         m_pend;
  int         k;
  int         nframes;
  bit         check_ok = 0;

  function automatic bit m_phase();
    return (nframes % (1 << BLINK_W)) >= (1 << (BLINK_W - 1));
  endfunction

  function automatic logic [NUM_DIGITS-1:0] m_les();
    return m_sh.les | (m_phase() ? m_sh.blink : '0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s k=%0d t=%0t actual=%0h required=%0h", name, k, $time, act, exp);
    end
  endtask

  task automatic check_now();
    chk("scan",        64'(bus.scan),        64'((k / TICK) % NUM_DIGITS));
    chk("scan_tick",   64'(bus.scan_tick),   64'((k % TICK) == TICK - 1));
    chk("frame_start", 64'(bus.frame_start), 64'((k % FRAME) == FRAME - 1));
    chk("wr_busy",     64'(bus.wr_busy),     64'(m_pend));
    chk("hexs",        64'(bus.hexs),        64'(m_sh.hex));
    chk("point",       64'(bus.point),       64'(m_sh.point));
    chk("les",         64'(bus.les),         64'(m_les()));
  endtask

  function automatic disp_word_t rand_word();
    disp_word_t w;
    w.hex   = $urandom();
    w.point = 8'($urandom());
    w.les   = 8'($urandom());
    w.blink = 8'($urandom());
    return w;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit we, input disp_word_t w);
    bit boundary;
    @(negedge clk);
    if (check_ok) check_now();
    if (r) begin
      m_sh = DISP_RESET; m_pw = '0; m_pend = 0; k = 0; nframes = 0; check_ok = 1;
    end else begin
      boundary = (k % FRAME) == FRAME - 1;
      if (boundary) nframes++;
      if (we && boundary) begin
        m_sh = w; m_pend = 0;
      end else if (we) begin
        m_pw = w; m_pend = 1;
      end else if (boundary && m_pend) begin
        m_sh = m_pw; m_pend = 0;
      end
      if (boundary) exp_q.push_back({m_sh.hex, m_sh.point, m_les(), m_pend});
      k++;
    end
    rst          = r;
    bus.wr_en    = we;
    bus.data_in  = we ? w.hex   : $urandom();
    bus.point_in = we ? w.point : 8'($urandom());
    bus.les_in   = we ? w.les   : 8'($urandom());
    bus.blink_in = we ? w.blink : 8'($urandom());
  endtask

  task automatic scenario(input int n, input int c1, input disp_word_t w1,
                          input int c2, input disp_word_t w2, input int rc);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    for (int c = 0; c < n; c++) begin
      if (c == rc)      step(1'b1, 1'b0, '0);
      else if (c == c1) step(1'b0, 1'b1, w1);
      else if (c == c2) step(1'b0, 1'b1, w2);
      else              step(1'b0, 1'b0, '0);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic         fs;
    logic [W-1:0] act, exp;
    fs = bus.frame_start && !rst;
    #1;
    if (fs === 1'b1) begin
      act = {bus.hexs, bus.point, bus.les, bus.wr_busy};
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL frame_commit t=%0t actual=%0h required=no frame boundary", $time, act);
      end else begin
        exp = exp_q.pop_front();
        chk("frame_commit", 64'(act), 64'(exp));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    disp_word_t w1, w2;
    bit r, we;

    w1 = '{hex: 32'h1234_ABCD, point: 8'h01, les: 8'h00, blink: 8'h00};
    scenario(70, 5, w1, -1, '0, -1);

    w1 = '{hex: 32'h1111_1111, point: 8'h00, les: 8'h00, blink: 8'h00};
    w2 = '{hex: 32'h2222_2222, point: 8'h80, les: 8'h00, blink: 8'h00};
    scenario(70, 5, w1, 20, w2, -1);

    w1 = '{hex: 32'hCAFE_0001, point: 8'h00, les: 8'h10, blink: 8'h00};
    scenario(45, 31, w1, -1, '0, -1);

    w1 = '{hex: 32'h0BAD_F00D, point: 8'h00, les: 8'h00, blink: 8'h0F};
    scenario(5 * FRAME + 4, 5, w1, -1, '0, -1);

    w1 = '{hex: 32'hDEAD_BEEF, point: 8'hFF, les: 8'h00, blink: 8'h00};
    scenario(45, 5, w1, -1, '0, 10);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    for (int c = 0; c < 600; c++) begin
      r  = ($urandom_range(0, 299) == 0);
      we = ($urandom_range(0, 5) == 0) ||
           ((k % FRAME) == FRAME - 1 && $urandom_range(0, 1) == 1);
      step(r, we, rand_word());
    end

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    @(negedge clk);
    chk("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
